// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: accepts a byte on a valid/ready handshake and
// serialises start, 8 data bits (LSB first), optional parity and stop bits.
module uart_tx_sequencer #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic              stop_q, stop_d;
   logic [7:0]        data_q, data_d;
   logic              parity_q, parity_d;
   logic              serial_q, serial_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         data_q   <= '0;
         parity_q <= 1'b0;
         serial_q <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         data_q   <= data_d;
         parity_q <= parity_d;
         serial_q <= serial_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Every output is registered, so the value for the next bit period is
   // loaded into serial_d on the boundary edge that ends the current one.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      data_d   = data_q;
      parity_d = parity_q;
      serial_d = serial_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      bit_end  = (baud_q == BAUD_LAST);

      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (tx_valid && ready_q) begin
               data_d   = tx_data;
               parity_d = (^tx_data) ^ (PARITY_ODD != 0);
               baud_d   = '0;
               bit_d    = '0;
               stop_d   = 1'b0;
               serial_d = 1'b0;
               ready_d  = 1'b0;
               busy_d   = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) begin
               serial_d = data_q[0];
               state_d  = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PARITY_EN != 0) begin
                     serial_d = parity_q;
                     state_d  = PARITY;
                  end else begin
                     serial_d = 1'b1;
                     state_d  = STOP;
                  end
               end else begin
                  bit_d    = bit_q + 3'd1;
                  serial_d = data_q[bit_q + 3'd1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               serial_d = 1'b1;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  stop_d   = 1'b0;
                  serial_d = 1'b1;
                  ready_d  = 1'b1;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign tx_serial = serial_q;
   assign tx_ready  = ready_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

endmodule
